// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate decode and extend, carried through PIPE_DEPTH registered stages.
// Latency PIPE_DEPTH cycles; stall holds every stage and drops inputs, flush clears all and wins over stall.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     inst_in,
    input  logic [3:0]      imm_sel_in,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] imm_out,
    output logic            valid_out,
    output logic            illegal_out
);

    // Format codes as defined in encordings.v; 3'd0 and 3'd7 are unused.
    localparam logic [2:0] IMM_TYPE1 = 3'd1;  // U
    localparam logic [2:0] IMM_TYPE2 = 3'd2;  // J
    localparam logic [2:0] IMM_TYPE3 = 3'd3;  // I
    localparam logic [2:0] IMM_TYPE4 = 3'd4;  // B
    localparam logic [2:0] IMM_TYPE5 = 3'd5;  // S
    localparam logic [2:0] IMM_TYPE6 = 3'd6;  // shamt

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            vld;
        logic            illegal;
    } stage_t;

    logic [63:0] wide_imm;
    logic        ext_bit;
    logic        dec_illegal;
    stage_t      stg [PIPE_DEPTH];

    // Decode into a 64-bit value and truncate, so one table serves both XLENs.
    always_comb begin
        wide_imm    = '0;
        dec_illegal = 1'b0;
        ext_bit     = inst_in[31] & ~imm_sel_in[3];
        case (imm_sel_in[2:0])
            IMM_TYPE1: wide_imm = {{32{inst_in[31]}}, inst_in[31:12], 12'b0};
            IMM_TYPE2: wide_imm = {{43{ext_bit}}, inst_in[31], inst_in[19:12],
                                   inst_in[20], inst_in[30:21], 1'b0};
            IMM_TYPE3: wide_imm = {{52{ext_bit}}, inst_in[31:20]};
            IMM_TYPE4: wide_imm = {{51{ext_bit}}, inst_in[31], inst_in[7],
                                   inst_in[30:25], inst_in[11:8], 1'b0};
            IMM_TYPE5: wide_imm = {{52{ext_bit}}, inst_in[31:25], inst_in[11:7]};
            IMM_TYPE6: begin
                if (XLEN == 32) wide_imm = {59'b0, inst_in[24:20]};
                else            wide_imm = {58'b0, inst_in[25:20]};
            end
            default:   dec_illegal = valid_in;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg[i] <= '0;
        end else if (!stall) begin
            stg[0].imm     <= wide_imm[XLEN-1:0];
            stg[0].vld     <= valid_in;
            stg[0].illegal <= dec_illegal;
            for (int i = 1; i < PIPE_DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign imm_out     = stg[PIPE_DEPTH-1].imm;
    assign valid_out   = stg[PIPE_DEPTH-1].vld;
    assign illegal_out = stg[PIPE_DEPTH-1].illegal;

endmodule
